// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and stall signals around mem_port_arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    output stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between a fetch (if) and a data (dm) requester.
// Data wins by default; a streak counter forces a fetch grant after MAX_STREAK data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_DM = 2'd2;

  localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

  logic [1:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_elig, dm_elig, grant_if, grant_dm;

  // A requester in its ready cycle still shows the request it just completed.
  assign if_elig = bus.if_req & ~if_ready_q;
  assign dm_elig = bus.dm_req & ~dm_ready_q;

  // Priority follows the raw dm request, so a dm requester in its ready cycle keeps its turn.
  assign grant_if = (state_q == IDLE) & if_elig & (~bus.dm_req | (streak_q == StreakMax));
  assign grant_dm = (state_q == IDLE) & dm_elig & ~grant_if;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = GNT_IF;
          streak_d    = 4'd0;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end else if (grant_dm) begin
          state_d     = GNT_DM;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (!bus.if_req) begin
            streak_d = 4'd0;
          end else if (streak_q >= StreakMax) begin
            streak_d = StreakMax;
          end else begin
            streak_d = streak_q + 4'd1;
          end
        end
      end
      GNT_IF: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          if_ready_d = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end
      end
      GNT_DM: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for streak fairness, memory wait states and reset mid-transaction.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        x_mem_req;
    logic [31:0] x_mem_addr;
    logic        x_mem_we;
    logic [31:0] x_mem_wdata;
    logic        x_if_ready;
    logic        x_dm_ready;
    logic        x_stall;
    logic [31:0] x_if_rdata;
    logic [31:0] x_dm_rdata;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dmr, input logic we,
                       input logic [31:0] dma, input logic [31:0] wd, input logic ack,
                       input logic [31:0] rd);
    bus.if_req    = ifr;
    bus.if_addr   = ifa;
    bus.dm_req    = dmr;
    bus.dm_we     = we;
    bus.dm_addr   = dma;
    bus.dm_wdata  = wd;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
  endtask

  initial begin
    logic       got [7];
    logic       exp_if [7];
    logic       prev;
    int         ngr;
    logic       x41_req [6];
    logic       x41_rdy [6];

    n_vec  = 0;
    n_miss = 0;
    // inputs: if_req if_addr dm_req dm_we dm_addr dm_wdata mem_ack mem_rdata
    // expect: mem_req mem_addr mem_we mem_wdata if_ready dm_ready stall if_rdata dm_rdata
    tbl[0]  = '{1, 32'h100, 0, 0, 0, 0, 1, 32'h00500093,
                0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 32'h100, 0, 0, 0, 0, 1, 32'h00500093,
                1, 32'h100, 0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 32'h100, 0, 0, 0, 0, 1, 32'h00500093,
                0, 32'h100, 0, 0, 1, 0, 0, 32'h00500093, 0};
    tbl[3]  = '{0, 32'h100, 0, 0, 0, 0, 0, 0,
                0, 32'h100, 0, 0, 0, 0, 0, 32'h00500093, 0};
    tbl[4]  = '{1, 32'h104, 1, 0, 32'h2000, 0, 0, 0,
                0, 32'h100, 0, 0, 0, 0, 1, 32'h00500093, 0};
    tbl[5]  = '{1, 32'h104, 1, 0, 32'h2000, 0, 1, 32'hAAAA0001,
                1, 32'h2000, 0, 0, 0, 0, 1, 32'h00500093, 0};
    tbl[6]  = '{1, 32'h104, 0, 0, 32'h2000, 0, 0, 0,
                0, 32'h2000, 0, 0, 0, 1, 1, 32'h00500093, 32'hAAAA0001};
    tbl[7]  = '{1, 32'h104, 0, 0, 0, 0, 1, 32'hBBBB0002,
                1, 32'h104, 0, 0, 0, 0, 1, 32'h00500093, 32'hAAAA0001};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h104, 0, 0, 1, 0, 0, 32'hBBBB0002, 32'hAAAA0001};
    tbl[9]  = '{0, 0, 1, 0, 32'h44, 0, 1, 32'h11,
                0, 32'h104, 0, 0, 0, 0, 1, 32'hBBBB0002, 32'hAAAA0001};
    tbl[10] = '{0, 0, 1, 0, 32'h44, 0, 1, 32'h11,
                1, 32'h44, 0, 0, 0, 0, 1, 32'hBBBB0002, 32'hAAAA0001};
    tbl[11] = '{0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0,
                0, 32'h44, 0, 0, 0, 1, 0, 32'hBBBB0002, 32'h11};
    tbl[12] = '{0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0,
                0, 32'h44, 0, 0, 0, 0, 1, 32'hBBBB0002, 32'h11};
    tbl[13] = '{0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h99999999,
                1, 32'h40, 1, 32'hDEADBEEF, 0, 0, 1, 32'hBBBB0002, 32'h11};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h40, 1, 32'hDEADBEEF, 0, 1, 0, 32'hBBBB0002, 32'h11};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 32'h55555555,
                0, 32'h40, 1, 32'hDEADBEEF, 0, 0, 0, 32'hBBBB0002, 32'h11};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 32'h55555555,
                0, 32'h40, 1, 32'hDEADBEEF, 0, 0, 0, 32'hBBBB0002, 32'h11};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset mem_req", 32'(bus.mem_req), 0);
    chk("reset dm_rdata", bus.dm_rdata, 0);
    #3 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].dm_req, tbl[i].dm_we, tbl[i].dm_addr,
            tbl[i].dm_wdata, tbl[i].mem_ack, tbl[i].mem_rdata);
      #1;
      chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(tbl[i].x_mem_req));
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].x_mem_addr);
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(tbl[i].x_mem_we));
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tbl[i].x_mem_wdata);
      chk($sformatf("v%0d if_ready", i), 32'(bus.if_ready), 32'(tbl[i].x_if_ready));
      chk($sformatf("v%0d dm_ready", i), 32'(bus.dm_ready), 32'(tbl[i].x_dm_ready));
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tbl[i].x_stall));
      chk($sformatf("v%0d if_rdata", i), bus.if_rdata, tbl[i].x_if_rdata);
      chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata, tbl[i].x_dm_rdata);
      tick();
    end

    // Streak fairness: fetch held, data stores held, zero-wait memory.
    exp_if = '{0, 0, 0, 0, 1, 0, 0};
    got    = '{0, 0, 0, 0, 0, 0, 0};
    drive(1, 32'h300, 1, 1, 32'h800, 32'h1000, 1, 0);
    prev = 1'b0;
    ngr  = 0;
    for (int c = 0; c < 60 && ngr < 7; c++) begin
      tick();
      if (bus.mem_req && !prev) begin
        got[ngr] = (bus.mem_addr == 32'h300);
        ngr++;
      end
      prev = bus.mem_req;
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) tick();
    chk("streak grant count", 32'(ngr), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("streak grant %0d is_if", i), 32'(got[i]), 32'(exp_if[i]));
    end
    bus.mem_ack = 1'b0;
    tick();

    // Three memory wait cycles with the fetch address moving during the wait.
    x41_req = '{0, 1, 1, 1, 1, 0};
    x41_rdy = '{0, 0, 0, 0, 0, 1};
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("wait c%0d mem_req", c), 32'(bus.mem_req), 32'(x41_req[c]));
      chk($sformatf("wait c%0d if_ready", c), 32'(bus.if_ready), 32'(x41_rdy[c]));
      if (c <= 4) chk($sformatf("wait c%0d mem_addr", c), bus.mem_addr, 32'h500);
      if (c == 1) bus.if_addr = 32'h5FC;
      if (c == 4) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234;
      end
      if (c == 5) begin
        chk("wait if_rdata", bus.if_rdata, 32'h1234);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    tick();
    chk("wait ready pulse ends", 32'(bus.if_ready), 0);

    // Reset lands mid-cycle while a data load is granted.
    drive(0, 0, 1, 0, 32'h700, 0, 0, 0);
    tick();
    chk("rst pre mem_req", 32'(bus.mem_req), 1);
    #3 reset = 1'b1;
    #1;
    chk("rst async mem_req", 32'(bus.mem_req), 0);
    chk("rst async mem_addr", bus.mem_addr, 0);
    chk("rst async if_rdata", bus.if_rdata, 0);
    chk("rst async dm_rdata", bus.dm_rdata, 0);
    tick();
    chk("rst held dm_ready", 32'(bus.dm_ready), 0);
    #3 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD);
    tick();
    chk("late ack dm_ready", 32'(bus.dm_ready), 0);
    chk("late ack dm_rdata", bus.dm_rdata, 0);
    chk("late ack mem_req", 32'(bus.mem_req), 0);
    drive(0, 0, 1, 0, 32'h710, 0, 1, 32'h77);
    tick();
    chk("post rst mem_req", 32'(bus.mem_req), 1);
    chk("post rst mem_addr", bus.mem_addr, 32'h710);
    tick();
    chk("post rst dm_ready", 32'(bus.dm_ready), 1);
    chk("post rst dm_rdata", bus.dm_rdata, 32'h77);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
